// File: rtl/cost_table_arbiter_if.sv
// Engine-side request/return bundle plus the shared cost-table port, seen by the arbiter as the slave.
// Engines hold req with W/J stable until granted; returns are one-cycle rvalid pulses on a shared rdata.
interface cost_table_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_w;
  logic [3*NREQ-1:0] req_j;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rvalid;
  logic [6:0]        rdata;
  logic [2:0]        W;
  logic [2:0]        J;
  logic              TEN;
  logic [6:0]        Cost;
  logic              busy;

  modport master (
    output req, req_w, req_j, Cost,
    input  gnt, rvalid, rdata, W, J, TEN, busy
  );

  modport slave (
    input  req, req_w, req_j, Cost,
    output gnt, rvalid, rdata, W, J, TEN, busy
  );
endinterface

// File: rtl/cost_table_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one cost-table port; gnt is combinational, W/J/TEN one cycle later,
// rvalid/rdata LAT+1 cycles after the grant cycle; an engine is stalled simply by leaving its gnt low.
module cost_table_arbiter #(
  parameter int NREQ     = 4,
  parameter int LAT      = 1,
  parameter int MAXBURST = 8
) (
  input logic                 CLK,
  input logic                 RST_N,
  cost_table_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IW-1:0]   idx_t;
  typedef logic [NREQ-1:0] vec_t;

  idx_t       owner_q, owner_d;
  logic       owner_vld_q, owner_vld_d;
  logic [3:0] beats_q, beats_d;
  idx_t       rr_ptr_q, rr_ptr_d;
  logic [2:0] w_q, w_d;
  logic [2:0] j_q, j_d;
  logic       ten_q, ten_d;

  logic [LAT-1:0] pipe_vld_q;
  idx_t           pipe_tag_q [LAT];
  vec_t           rvalid_q;
  logic [6:0]     rdata_q;

  logic any_req;
  logic other_req;
  logic keep;
  idx_t sel;
  vec_t gnt;

  // The current owner is kept unless its burst is spent and someone else is waiting.
  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    any_req   = |bus.req;
    other_req = |(bus.req & ~(vec_t'(1) << owner_q));
    keep      = owner_vld_q && bus.req[owner_q] &&
                ((beats_q < 4'(MAXBURST)) || !other_req);
    sel       = owner_q;
    if (!keep) begin
      sel = rr_ptr_q;
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NREQ;
        if (!found && bus.req[idx_t'(idx)]) begin
          sel   = idx_t'(idx);
          found = 1'b1;
        end
      end
    end
    gnt = any_req ? (vec_t'(1) << sel) : '0;
  end

  always_comb begin
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    beats_d     = beats_q;
    rr_ptr_d    = rr_ptr_q;
    w_d         = w_q;
    j_d         = j_q;
    ten_d       = 1'b0;
    if (any_req) begin
      owner_d     = sel;
      owner_vld_d = 1'b1;
      rr_ptr_d    = (sel == idx_t'(NREQ - 1)) ? '0 : sel + idx_t'(1);
      beats_d     = !keep ? 4'd1 :
                    (beats_q < 4'(MAXBURST)) ? beats_q + 4'd1 : beats_q;
      w_d         = bus.req_w[3*int'(sel) +: 3];
      j_d         = bus.req_j[3*int'(sel) +: 3];
      ten_d       = 1'b1;
    end else begin
      owner_vld_d = 1'b0;
      beats_d     = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      beats_q     <= '0;
      rr_ptr_q    <= '0;
      w_q         <= '0;
      j_q         <= '0;
      ten_q       <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      beats_q     <= beats_d;
      rr_ptr_q    <= rr_ptr_d;
      w_q         <= w_d;
      j_q         <= j_d;
      ten_q       <= ten_d;
    end
  end

  // Tag pipe: the stage leaving at grant edge + LAT captures Cost for its requester.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pipe_vld_q <= '0;
      for (int s = 0; s < LAT; s++) pipe_tag_q[s] <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      pipe_vld_q[0] <= any_req;
      pipe_tag_q[0] <= sel;
      for (int s = 1; s < LAT; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_tag_q[s] <= pipe_tag_q[s-1];
      end
      rvalid_q <= pipe_vld_q[LAT-1] ? (vec_t'(1) << pipe_tag_q[LAT-1]) : '0;
      if (pipe_vld_q[LAT-1]) rdata_q <= bus.Cost;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.W      = w_q;
  assign bus.J      = j_q;
  assign bus.TEN    = ten_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = owner_vld_q | (|pipe_vld_q);
endmodule

// File: tb/tb_cost_table_arbiter.sv
// Randomized bench for cost_table_arbiter: a policy model predicts each grant, a scoreboard matches returns.
module tb_cost_table_arbiter;
  localparam int NREQ     = 4;
  localparam int LAT      = 2;
  localparam int MAXBURST = 3;

  logic CLK = 1'b0;
  logic RST_N;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  cost_table_arbiter_if #(.NREQ(NREQ)) bus ();

  cost_table_arbiter #(.NREQ(NREQ), .LAT(LAT), .MAXBURST(MAXBURST)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Cost table: random contents, read data appears LAT-1 cycles after W/J are presented.
  logic [6:0] rom [8][8];
  logic [5:0] wj_hist;
  always @(posedge CLK) wj_hist <= {bus.W, bus.J};
  assign bus.Cost = rom[wj_hist[5:3]][wj_hist[2:0]];

  typedef struct {
    int         tag;
    logic [6:0] cost;
    int         due;
  } exp_t;
  exp_t sbq[$];

  // Reference: who won last, how long their unbroken run is, and where rotation resumes.
  int              m_last, m_run, m_start;
  bit              m_own;
  bit              gh[$];
  logic [2:0]      e_w, e_j;
  logic            e_ten;
  logic [NREQ-1:0] gprev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 0; m_run = 0; m_start = 0; m_own = 0;
    gh.delete();
    e_w = '0; e_j = '0; e_ten = 1'b0;
    gprev = '0;
  endtask

  task automatic drive(input logic [NREQ-1:0] mask, input int pct);
    logic [NREQ-1:0]   r;
    logic [3*NREQ-1:0] w, j;
    r = bus.req; w = bus.req_w; j = bus.req_j;
    for (int i = 0; i < NREQ; i++) begin
      if (!r[i] || gprev[i]) begin
        r[i] = mask[i] && ($urandom_range(99) < pct);
        w[3*i +: 3] = 3'($urandom_range(7));
        j[3*i +: 3] = 3'($urandom_range(7));
      end
    end
    bus.req = r; bus.req_w = w; bus.req_j = j;
  endtask

  task automatic evaluate();
    logic [NREQ-1:0] r, oth, eg;
    int              win;
    bit              busy_e;
    r      = bus.req;
    busy_e = m_own;
    foreach (gh[k]) if (gh[k]) busy_e = 1;
    check("TEN", 32'(bus.TEN), 32'(e_ten));
    check("W", 32'(bus.W), 32'(e_w));
    check("J", 32'(bus.J), 32'(e_j));
    check("busy", 32'(bus.busy), 32'(busy_e));
    win = -1;
    oth = r;
    oth[m_last] = 1'b0;
    if (r != 0) begin
      if (m_own && r[m_last] && (m_run < MAXBURST || oth == 0)) win = m_last;
      else
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && r[(m_start + k) % NREQ]) win = (m_start + k) % NREQ;
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    check("gnt", 32'(bus.gnt), 32'(eg));
    gprev = eg;
    if (win >= 0) begin
      e_w   = bus.req_w[3*win +: 3];
      e_j   = bus.req_j[3*win +: 3];
      e_ten = 1'b1;
      sbq.push_back('{tag: win, cost: rom[e_w][e_j], due: cyc + LAT + 1});
      m_run   = (m_own && win == m_last) ? ((m_run < MAXBURST) ? m_run + 1 : MAXBURST) : 1;
      m_last  = win;
      m_start = (win + 1) % NREQ;
      m_own   = 1;
    end else begin
      e_ten = 1'b0;
      m_own = 0;
      m_run = 0;
    end
    gh.push_back(win >= 0);
    if (gh.size() > LAT) void'(gh.pop_front());
  endtask

  task automatic phase(input logic [NREQ-1:0] mask, input int pct, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge CLK); #1;
      drive(mask, pct);
      @(negedge CLK);
      evaluate();
    end
  endtask

  // Return monitor: every rvalid pulse must match the oldest outstanding lookup, on its due cycle.
  initial begin
    exp_t            e;
    logic [NREQ-1:0] ev;
    forever begin
      @(negedge CLK);
      if (bus.rvalid != 0) begin
        if (sbq.size() == 0) begin
          check("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
        end else begin
          e  = sbq.pop_front();
          ev = '0;
          ev[e.tag] = 1'b1;
          check("rvalid_tag", 32'(bus.rvalid), 32'(ev));
          check("rdata", 32'(bus.rdata), 32'(e.cost));
          check("ret_cycle", cyc, e.due);
        end
      end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        check("rvalid_missing", 32'(bus.rvalid), 32'(1) << e.tag);
      end
    end
  end

  initial begin
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) rom[a][b] = 7'($urandom_range(127));
    bus.req = '0; bus.req_w = '0; bus.req_j = '0;
    model_reset();
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_W", 32'(bus.W), 32'd0);
    check("rst_J", 32'(bus.J), 32'd0);
    check("rst_TEN", 32'(bus.TEN), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    phase(4'b0000, 0, 20);      // idle after release
    phase(4'b0100, 100, 1);     // single lookup from engine 2
    phase(4'b0000, 0, 5);
    phase(4'b0011, 100, 24);    // two engines, burst then rotate
    phase(4'b1111, 100, 40);    // everyone, fairness
    phase(4'b1000, 100, 12);    // lone owner saturates its run
    phase(4'b1010, 100, 12);    // newcomer forces rotation
    phase(4'b1000, 100, 6);
    phase(4'b1111, 60, 250);
    for (int p = 0; p < 20; p++) phase(4'($urandom_range(15)), 40, 10);

    // Reset with lookups in flight.
    phase(4'b1010, 100, 2);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    model_reset();
    sbq.delete();
    @(negedge CLK);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_rvalid", 32'(bus.rvalid), 32'd0);
    check("midrst_TEN", 32'(bus.TEN), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    evaluate();
    phase(4'b1111, 70, 60);
    phase(4'b0000, 0, 10);
    check("drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
